vect_mem_access_unit: RTL
=========================

Name: vect_mem_access_unit

Overview:
Sequencer that sits directly upstream of the vector data memory (6 lanes x 8 bit, word-indexed by A[13:2], combinational read, write on clk edge). It accepts one burst request (load or store of N consecutive or strided 48-bit vector words), drives the memory's A/WE/WD, streams load data out and store data in with valid/ready handshakes, range-checks every address and signals completion with a one-cycle done pulse.

Parameters:
MEM_WORDS, 102, number of valid vector words in the memory; word index >= MEM_WORDS is out of range
MAX_BURST, 15, largest req_count accepted (req_count width is 4 bits)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  burst request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_store  in  1  1 = store burst, 0 = load burst
req_base  in  32  byte address of first word
req_count  in  4  number of words, 0..MAX_BURST
req_stride  in  4  word stride; address step = req_stride*4 bytes (0 = same word repeatedly)
st_valid  in  1  store beat present
st_ready  out  1  store beat accepted this cycle
st_data  in  48  store vector [5:0][7:0], lane 0 in bits 7:0
ld_valid  out  1  load beat valid
ld_ready  in  1  consumer accepts load beat
ld_data  out  48  load vector
ld_last  out  1  marks final beat of the burst
mem_A  out  32  memory byte address
mem_WE  out  1  memory write enable
mem_WD  out  48  memory write data
mem_RD  in  48  memory read data (combinational from mem_A)
done  out  1  one-cycle pulse at burst end
err  out  1  valid with done; 1 = burst aborted
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at posedge): state IDLE; cur_addr, idx, count, stride, op cleared; ld_valid, ld_last, ld_data, done, err = 0; any pending load beat discarded; reset mid-burst aborts with no done pulse. mem_WE = 0 while rst is high.
- States: IDLE, LOAD, DRAIN, STORE, DONE.
- IDLE: req_ready=1. On req_valid: latch base into cur_addr, count, stride, op; idx=0. If req_base[1:0]!=0 -> DONE with err=1. Else if req_count==0 -> DONE with err=0, no memory access. Else -> LOAD or STORE.
- In range = cur_addr[31:14]==0 and cur_addr[13:2] < MEM_WORDS. mem_A = cur_addr in every state; mem_WD = st_data.
- LOAD: capture allowed when !ld_valid or ld_ready. On capture of an in-range address: ld_data<=mem_RD, ld_valid<=1, ld_last<=(idx==count-1), idx++, cur_addr += stride<<2; after the last capture -> DRAIN. If the address is out of range: no capture; go DONE with err=1 once the output register is empty or being consumed (earlier beats still delivered).
- ld_valid stays high, data stable, until ld_ready; ld_valid drops the cycle after acceptance unless a new capture occurs (back-to-back: 1 beat/cycle when ld_ready held high).
- DRAIN: wait for ld_valid && ld_ready on the last beat -> DONE.
- STORE: in range: st_ready=1, mem_WE = st_valid (combinational); on st_valid: write happens, idx++, cur_addr += stride<<2; after the last write -> DONE. Out of range: st_ready=0, mem_WE=0, -> DONE with err=1 (no partial write of that beat).
- DONE: done=1 for exactly one cycle, err held for that cycle, req_ready=0; next -> IDLE.
- Latency: request accepted at cycle T -> first ld_valid at T+2; first store write at T+1 when st_valid. Unloaded load burst of N: done at T+N+2. Store of N with st_valid held high: done at T+N+1.
- Address arithmetic wraps mod 2^32; the wrapped address fails the range check (err).
- req_valid is ignored outside IDLE; st_valid is ignored outside STORE.

Test Plan:
- Load base=0x08, count=3, stride=1, ld_ready=1, RAM[2..4]=A,B,C -> beats A,B,C on consecutive cycles, ld_last on C, done at T+5, err=0.
- Store base=0x10, count=2, stride=2, st_data 0x0102030405_06 then 0xAABBCCDDEEFF -> writes to word 4 and word 6; read back matches; done at T+3.
- Load count=4 with ld_ready toggled 1,0,0,1,... -> each beat held stable while ld_ready=0; no beat lost or duplicated; ld_last only on beat 4.
- Store base=0x190 (word 100), count=3, stride=1 -> words 100,101 written, word 102 not written, st_ready=0 on third beat, done with err=1.
- Edge requests: count=0 -> done at T+1, err=0, mem_WE never asserted; base=0x06 -> done with err=1, no access.
- rst asserted mid-load after 2 of 5 beats -> next cycle ld_valid=0, busy=0, req_ready=1, no done; a new request then completes normally.

Source files
------------

// File: rtl/vect_mem_access_unit_if.sv
// Request, load-stream, store-stream and memory-port signals of the vector memory sequencer.
interface vect_mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [31:0] req_base;
    logic [3:0]  req_count;
    logic [3:0]  req_stride;
    logic        st_valid;
    logic        st_ready;
    logic [47:0] st_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [47:0] ld_data;
    logic        ld_last;
    logic [31:0] mem_A;
    logic        mem_WE;
    logic [47:0] mem_WD;
    logic [47:0] mem_RD;
    logic        done;
    logic        err;
    logic        busy;

    modport master (
        output req_valid, req_store, req_base, req_count, req_stride,
        output st_valid, st_data, ld_ready, mem_RD,
        input  req_ready, st_ready, ld_valid, ld_data, ld_last,
        input  mem_A, mem_WE, mem_WD, done, err, busy
    );

    modport slave (
        input  req_valid, req_store, req_base, req_count, req_stride,
        input  st_valid, st_data, ld_ready, mem_RD,
        output req_ready, st_ready, ld_valid, ld_data, ld_last,
        output mem_A, mem_WE, mem_WD, done, err, busy
    );
endinterface

// File: rtl/vect_mem_access_unit.sv
// Burst sequencer for the 6x8-bit vector data memory: strided load/store bursts with
// range checking, a registered load output stage and a one-cycle done/err pulse.
module vect_mem_access_unit #(
    parameter int unsigned MEM_WORDS = 102,
    parameter int unsigned MAX_BURST = 15
) (
    input logic clk,
    input logic rst,
    vect_mem_access_unit_if.slave bus
);
    localparam int unsigned IW = $clog2(MAX_BURST + 1);
    localparam logic [11:0] WORD_LIMIT = 12'(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, STORE, DONE} state_t;

    state_t        state;
    logic [31:0]   cur_addr;
    logic [IW-1:0] idx;
    logic [IW-1:0] count;
    logic [3:0]    stride;
    logic          ld_valid;
    logic          ld_last;
    logic [47:0]   ld_data;
    logic          done;
    logic          err;

    logic          in_range;
    logic          can_cap;
    logic          last_idx;
    logic [31:0]   next_addr;

    always_comb begin
        in_range  = (cur_addr[31:14] == '0) && (cur_addr[13:2] < WORD_LIMIT);
        can_cap   = !ld_valid || bus.ld_ready;
        last_idx  = (idx == count - 1'b1);
        next_addr = cur_addr + {26'b0, stride, 2'b00};
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.st_ready  = (state == STORE) && in_range;
    assign bus.mem_WE    = !rst && (state == STORE) && in_range && bus.st_valid;
    assign bus.mem_A     = cur_addr;
    assign bus.mem_WD    = bus.st_data;
    assign bus.ld_valid  = ld_valid;
    assign bus.ld_last   = ld_last;
    assign bus.ld_data   = ld_data;
    assign bus.done      = done;
    assign bus.err       = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_addr <= '0;
            idx      <= '0;
            count    <= '0;
            stride   <= '0;
            ld_valid <= 1'b0;
            ld_last  <= 1'b0;
            ld_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cur_addr <= bus.req_base;
                        count    <= bus.req_count[IW-1:0];
                        stride   <= bus.req_stride;
                        idx      <= '0;
                        if (bus.req_base[1:0] != 2'b00) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (bus.req_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b0;
                        end else begin
                            state <= bus.req_store ? STORE : LOAD;
                        end
                    end
                end
                LOAD: begin
                    // An out-of-range address waits until earlier beats have left the output stage.
                    if (in_range) begin
                        if (can_cap) begin
                            ld_data  <= bus.mem_RD;
                            ld_valid <= 1'b1;
                            ld_last  <= last_idx;
                            idx      <= idx + 1'b1;
                            cur_addr <= next_addr;
                            if (last_idx) state <= DRAIN;
                        end
                    end else if (can_cap) begin
                        ld_valid <= 1'b0;
                        ld_last  <= 1'b0;
                        state    <= DONE;
                        done     <= 1'b1;
                        err      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (ld_valid && bus.ld_ready) begin
                        ld_valid <= 1'b0;
                        ld_last  <= 1'b0;
                        state    <= DONE;
                        done     <= 1'b1;
                        err      <= 1'b0;
                    end
                end
                STORE: begin
                    if (!in_range) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (bus.st_valid) begin
                        idx      <= idx + 1'b1;
                        cur_addr <= next_addr;
                        if (last_idx) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
